// File: rtl/avalon_bcd_display_writer.sv
// Avalon-MM master that converts a binary value to BCD (shift-and-add-3, one
// bit per cycle) and writes one digit per address to a seven-segment display slave.
module avalon_bcd_display_writer #(
    parameter int NUM_SEGMENT = 6,
    parameter int VALUE_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [VALUE_WIDTH-1:0] value_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [2:0]             avm_address_o,
    output logic [3:0]             avm_byteenable_o,
    output logic                   avm_write_o,
    output logic [31:0]            avm_writedata_o,
    input  logic                   avm_waitrequest_i,
    output logic                   overflow_o,
    output logic                   done_o
);
    localparam int CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam logic [VALUE_WIDTH:0] MAX_VAL  = (VALUE_WIDTH+1)'(10**NUM_SEGMENT - 1);
    localparam logic [2:0]           LAST_IDX = 3'(NUM_SEGMENT - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, WRITE} state_t;

    state_t                        state, state_nxt;
    logic [VALUE_WIDTH-1:0]        shift_q, shift_nxt;
    logic [NUM_SEGMENT-1:0][3:0]   bcd_q, bcd_adj, bcd_nxt;
    logic [CNT_W-1:0]              cnt_q;
    logic                          ovf_in, last_bit, wr_ack, last_wr;
    logic [2:0]                    idx_nxt;

    assign ovf_in   = {1'b0, value_i} > MAX_VAL;
    assign last_bit = (cnt_q == CNT_W'(1));
    assign wr_ack   = avm_write_o && !avm_waitrequest_i;
    assign last_wr  = wr_ack && (avm_address_o == LAST_IDX);
    assign idx_nxt  = avm_address_o + 3'd1;
    assign ready_o  = (state == IDLE);

    // Digit correction is per digit with no carry; the shift then moves the
    // top bit of each digit into the next one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_SEGMENT; i++)
            if (bcd_q[i] >= 4'd5)
                bcd_adj[i] = bcd_q[i] + 4'd3;
        {bcd_nxt, shift_nxt} = {bcd_adj, shift_q} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i)  state_nxt = ovf_in ? WRITE : CONVERT;
            CONVERT: if (last_bit) state_nxt = WRITE;
            WRITE:   if (last_wr)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q          <= '0;
            bcd_q            <= '0;
            cnt_q            <= '0;
            overflow_o       <= 1'b0;
            done_o           <= 1'b0;
            avm_write_o      <= 1'b0;
            avm_address_o    <= '0;
            avm_byteenable_o <= '0;
            avm_writedata_o  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (valid_i) begin
                    shift_q    <= value_i;
                    cnt_q      <= CNT_W'(VALUE_WIDTH);
                    overflow_o <= ovf_in;
                    if (ovf_in) begin
                        // Out-of-range values skip conversion and show 'E' on every digit.
                        bcd_q            <= {NUM_SEGMENT{4'hE}};
                        avm_write_o      <= 1'b1;
                        avm_address_o    <= 3'd0;
                        avm_byteenable_o <= 4'b0001;
                        avm_writedata_o  <= {28'b0, 4'hE};
                    end else begin
                        bcd_q <= '0;
                    end
                end
                CONVERT: begin
                    bcd_q   <= bcd_nxt;
                    shift_q <= shift_nxt;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (last_bit) begin
                        avm_write_o      <= 1'b1;
                        avm_address_o    <= 3'd0;
                        avm_byteenable_o <= 4'b0001;
                        avm_writedata_o  <= {28'b0, bcd_nxt[0]};
                    end
                end
                WRITE: if (wr_ack) begin
                    if (last_wr) begin
                        avm_write_o      <= 1'b0;
                        avm_address_o    <= 3'd0;
                        avm_byteenable_o <= 4'b0000;
                        avm_writedata_o  <= '0;
                        done_o           <= 1'b1;
                    end else begin
                        avm_address_o   <= idx_nxt;
                        avm_writedata_o <= {28'b0, bcd_q[idx_nxt]};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/avalon_bcd_display_writer.md
Name: avalon_bcd_display_writer

Overview:
- Avalon-MM master that sits directly upstream of the six-digit seven-segment display slave.
- Accepts an unsigned binary value over a valid/ready handshake and converts it to BCD iteratively (shift-and-add-3, one bit per cycle).
- Issues one Avalon write per digit so the display shows the decimal value.
- Flags values that do not fit in NUM_SEGMENT decimal digits.

Parameters:
- NUM_SEGMENT, 6, number of display digits; legal range 1..8 (address is 3 bits).
- VALUE_WIDTH, 20, width of binary input; must satisfy 2^VALUE_WIDTH > 10^NUM_SEGMENT - 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- value_i  input  VALUE_WIDTH  unsigned binary value to display.
- valid_i  input  1  value_i is valid.
- ready_o  output  1  block can accept a new value (high only in IDLE).
- avm_address_o  output  3  digit index of current write (0 = least significant digit).
- avm_byteenable_o  output  4  byte enables of current write.
- avm_write_o  output  1  Avalon write request.
- avm_writedata_o  output  32  write data; the digit is in bits [3:0].
- avm_waitrequest_i  input  1  slave stall; the write is accepted when avm_write_o=1 and avm_waitrequest_i=0.
- overflow_o  output  1  the last accepted value exceeded 10^NUM_SEGMENT - 1.
- done_o  output  1  one-cycle pulse: all digit writes for the current value completed.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready_o=1.
  - avm_write_o=0, avm_address_o=0, avm_byteenable_o=0, avm_writedata_o=0.
  - overflow_o=0, done_o=0; BCD register and bit counter cleared.
  - A reset mid-conversion or mid-write aborts immediately: avm_write_o drops asynchronously and no further writes are issued. Digits already written remain in the slave.
- All Avalon outputs are driven from registers.
- States: IDLE, CONVERT, WRITE.
- IDLE:
  - ready_o=1.
  - On valid_i=1: latch value_i into the shift register, clear the BCD register, set the bit counter to VALUE_WIDTH.
  - Set overflow_o = (value_i > 10^NUM_SEGMENT - 1); it holds until the next accept.
  - If no overflow, go to CONVERT.
  - If overflow, load every BCD digit with 4'hE and go directly to WRITE.
- CONVERT:
  - Each cycle, every BCD digit >= 5 gets +3 (4-bit, no carry between digits).
  - Then {bcd, shift} shifts left by 1.
  - The bit counter decrements; after exactly VALUE_WIDTH cycles, go to WRITE with digit index 0.
  - ready_o=0.
- WRITE:
  - avm_write_o=1.
  - avm_address_o=index.
  - avm_byteenable_o=4'b0001.
  - avm_writedata_o={28'b0, bcd digit[index]}.
  - While avm_waitrequest_i=1, all Avalon outputs hold unchanged.
  - On acceptance, index increments and the next write's outputs appear the following cycle, so there are no idle cycles between writes.
  - After index NUM_SEGMENT-1 is accepted: avm_write_o=0, state=IDLE, and done_o=1 for exactly that first IDLE cycle (ready_o=1 in the same cycle).
- Latency with no wait states, accept in cycle 0:
  - Normal path: writes in cycles VALUE_WIDTH+1 .. VALUE_WIDTH+NUM_SEGMENT (21..26); done_o in cycle 27.
  - Overflow path: writes in cycles 1..NUM_SEGMENT; done_o in cycle NUM_SEGMENT+1 (7).
- valid_i while ready_o=0 is ignored; it is not queued.
- valid_i in the done_o cycle is accepted normally (back-to-back operation).
- Leading zeros are written as 0; there is no blanking.

Test Plan:
- Reset, then value_i=123456, valid_i=1 for 1 cycle, waitrequest=0 -> writes (addr,data) = (0,6)(1,5)(2,4)(3,3)(4,2)(5,1), byteenable 4'b0001 each, in cycles 21-26; done_o=1 in cycle 27; overflow_o=0.
- value_i=0 then value_i=999999 -> all six writes carry data 0, then all six carry 9; overflow_o=0 both times.
- value_i=1000000 -> overflow_o=1; six writes of 0xE at addr 0..5 in cycles 1-6; done_o in cycle 7. A following value_i=42 clears overflow_o and writes 2,4,0,0,0,0.
- value_i=654321 with avm_waitrequest_i=1 for 3 cycles during the addr=2 write -> addr=2 and data=3 held stable for 4 cycles; done_o delayed by 3 cycles to cycle 30.
- valid_i pulsed with value 111111 during CONVERT of 222222 -> ignored; only digits 2 are written. Then valid_i asserted in the done_o cycle -> new value accepted with no gap.
- rst_n=0 during the addr=3 write -> avm_write_o=0 immediately with no further writes; after release, ready_o=1, overflow_o=0, done_o never pulses for the aborted value.
